// File: rtl/clk_mon_pkg.sv
// ============================================================================
//  Module      : clk_mon_pkg
//  Description : Shared types and constants for clock_div_monitor: FSM state
//                encoding, default counter width and its terminal value, and a
//                saturating increment helper for the 8-bit error counter.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package clk_mon_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        TMO  = 2'd3
    } state_t;

    // Default counter width and the count at which a dead clock is declared
    localparam int CNT_W_DEF = 8;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    // Saturating increment for the mismatch counter
    function automatic logic [7:0] err_sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_div_monitor_if.sv
// ============================================================================
//  Module      : clock_div_monitor_if
//  Description : Bundle of the clock-monitor stimulus (sig_in, clr) and its
//                measurement/status results. master drives the clock under
//                test, slave is the monitor itself.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface clock_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_count;
    logic             timeout;

    modport master (
        output sig_in, clr,
        input  period, high_time, meas_valid, locked, err_pulse, err_count, timeout
    );

    modport slave (
        input  sig_in, clr,
        output period, high_time, meas_valid, locked, err_pulse, err_count, timeout
    );
endinterface

`default_nettype wire

// File: rtl/clk_mon_edge_det.sv
// ============================================================================
//  Module      : clk_mon_edge_det
//  Description : Samples the clock under test on clk_in and produces single-
//                cycle rise/fall strobes from the current and previous sample.
//                Macro CLK_MON_SYNC_EN inserts a 2-flop synchronizer ahead of
//                the sampling register for sources from another clock domain.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_mon_edge_det (
    input  wire logic clk_in,
    input  wire logic rst,
    input  wire logic sig_in,
    output logic      rise,
    output logic      fall
);

    logic samp_src;

`ifdef CLK_MON_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchronizer next-state: shift sig_in through two stages
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign samp_src = sync2_q;
`else
    assign samp_src = sig_in;
`endif

    // samp_q is the sample s; samp_prev_q is the previous sample s_d
    logic samp_q,      samp_d;
    logic samp_prev_q, samp_prev_d;

    // Sample pipeline next-state
    always_comb begin
        samp_d      = samp_src;
        samp_prev_d = samp_q;
    end

    // Sampling and history flops
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            samp_q      <= 1'b0;
            samp_prev_q <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            samp_prev_q <= samp_prev_d;
        end
    end

    assign rise = samp_q & ~samp_prev_q;
    assign fall = ~samp_q & samp_prev_q;

endmodule

`default_nettype wire

// File: rtl/clock_div_monitor.sv
// ============================================================================
//  Module      : clock_div_monitor
//  Description : On-chip checker for a divided clock. Measures period and high
//                time in clk_in cycles, compares each period against
//                EXP_PERIOD +/- TOL, asserts locked after LOCK_CNT consecutive
//                matches, counts mismatches and flags a dead clock.
//                Optional macro: CLK_MON_SYNC_EN (2-flop input synchronizer).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clock_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EXP_PERIOD = 26,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4
) (
    input  wire logic          clk_in,
    input  wire logic          rst,
    clock_div_monitor_if.slave bus
);

    // Terminal count: reaching it without an edge means the clock is dead
    localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};
    // Tolerance window, one bit wider than the counter so it never wraps
    localparam logic [CNT_W:0]   EXP_W    = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]   LO_BOUND = (EXP_PERIOD >= TOL) ? (EXP_W - TOL_W) : '0;
    localparam logic [CNT_W:0]   HI_BOUND = EXP_W + TOL_W;
    localparam int               MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_CNT);

    logic rise, fall;

    clk_mon_edge_det u_edge_det (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (bus.sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [CNT_W-1:0]   hi_r_q,       hi_r_d;
    logic [CNT_W-1:0]   period_q,     period_d;
    logic [CNT_W-1:0]   high_time_q,  high_time_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q,     locked_d;
    logic               err_pulse_q,  err_pulse_d;
    logic [7:0]         err_count_q,  err_count_d;
    logic               timeout_q,    timeout_d;
    logic [MATCH_W-1:0] match_q,      match_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W:0]     period_ext;
    logic               in_tol;

    // Next-state: measurement FSM, period checker and dead-clock detection
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_r_d       = hi_r_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        timeout_d    = timeout_q;
        match_d      = match_q;

        cnt_inc    = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
        period_ext = {1'b0, period_q};
        in_tol     = (period_ext >= LO_BOUND) && (period_ext <= HI_BOUND);

        if (bus.clr) begin
            state_d     = IDLE;
            cnt_d       = '0;
            match_d     = '0;
            locked_d    = 1'b0;
            err_count_d = 8'd0;
            timeout_d   = 1'b0;
        end else begin
            // Judge the measurement published last cycle
            if (meas_valid_q) begin
                if (in_tol) begin
                    match_d  = (match_q == LOCK_TARGET) ? match_q : match_q + 1'b1;
                    locked_d = (match_d == LOCK_TARGET);
                end else begin
                    err_pulse_d = 1'b1;
                    err_count_d = err_sat_inc(err_count_q);
                    match_d     = '0;
                    locked_d    = 1'b0;
                end
            end

            case (state_q)
                // First rise only starts counting; nothing to publish yet
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_r_d  = cnt_q;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        high_time_d  = hi_r_q;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_W'(1);
                        state_d      = HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // Dead clock: hold the count and wait for activity to resume
                TMO: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            if ((state_d != TMO) && (cnt_d == CNT_TOP)) begin
                state_d   = TMO;
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                match_d   = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_r_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= 8'd0;
            timeout_q    <= 1'b0;
            match_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_r_q       <= hi_r_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            timeout_q    <= timeout_d;
            match_q      <= match_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_div_monitor.sv
// ============================================================================
//  Module      : tb_clock_div_monitor
//  Description : Self-checking bench for clock_div_monitor. Expected
//                measurements are queued when a rise is driven and popped when
//                meas_valid is seen; status outputs are compared against a
//                small behavioural model of the checker.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clock_div_monitor;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0] per;
        logic [7:0] hi;
    } meas_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    clock_div_monitor_if #(.CNT_W(CNT_W)) bus ();

    clock_div_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (26),
        .TOL        (1),
        .LOCK_CNT   (4)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int    tests = 0;
    int    fails = 0;
    meas_t exp_q[$];
    int    meas_pushed = 0;
    int    meas_seen   = 0;
    int    err_seen    = 0;

    // Reference model of the checker
    bit    armed      = 1'b0;
    int    prev_hi    = 0;
    int    prev_lo    = 0;
    int    exp_match  = 0;
    bit    exp_locked = 1'b0;
    int    exp_err    = 0;
    int    exp_errs_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic model_meas(input int per, input int hi);
        meas_t m;
        m.per = 8'(per);
        m.hi  = 8'(hi);
        exp_q.push_back(m);
        meas_pushed++;
        if (per >= 25 && per <= 27) begin
            if (exp_match < 4) exp_match++;
            exp_locked = (exp_match == 4);
        end else begin
            if (exp_err < 255) exp_err++;
            exp_errs_total++;
            exp_match  = 0;
            exp_locked = 1'b0;
        end
    endtask

    task automatic model_restart();
        armed      = 1'b0;
        exp_match  = 0;
        exp_locked = 1'b0;
    endtask

    // One full cycle of the clock under test: hi cycles high then lo cycles low
    task automatic pulse(input int hi, input int lo);
        if (armed) model_meas(prev_hi + prev_lo, prev_hi);
        armed   = 1'b1;
        prev_hi = hi;
        prev_lo = lo;
        bus.sig_in = 1'b1;
        idle(hi);
        bus.sig_in = 1'b0;
        idle(lo);
    endtask

    task automatic pulses(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) pulse(hi, lo);
    endtask

    // Scoreboard: compare every published measurement with the queue head
    always @(negedge clk_in) begin
        if (rst) begin
            if (bus.err_pulse) err_seen++;
            if (bus.meas_valid) begin
                meas_t m;
                meas_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_meas", 32'd1, 32'd0);
                end else begin
                    m = exp_q.pop_front();
                    check("meas_period", 32'(bus.period), 32'(m.per));
                    check("meas_high_time", 32'(bus.high_time), 32'(m.hi));
                end
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_locked"},    32'(bus.locked),    32'(exp_locked));
        check({tag, "_err_count"}, 32'(bus.err_count), 32'(exp_err));
    endtask

    initial begin
        bus.sig_in = 1'b0;
        bus.clr    = 1'b0;
        rst        = 1'b0;
        @(posedge clk_in);
        #1;
        idle(2);

        // Reset state
        check("rst_period",     32'(bus.period),     32'd0);
        check("rst_high_time",  32'(bus.high_time),  32'd0);
        check("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
        check("rst_locked",     32'(bus.locked),     32'd0);
        check("rst_err_pulse",  32'(bus.err_pulse),  32'd0);
        check("rst_err_count",  32'(bus.err_count),  32'd0);
        check("rst_timeout",    32'(bus.timeout),    32'd0);
        rst = 1'b1;
        idle(3);

        // 1: nominal 13/13 clock, lock after the 4th measurement
        pulses(13, 13, 4);
        check("t1_not_locked_after_3", 32'(bus.locked), 32'd0);
        pulses(13, 13, 2);
        check_status("t1");
        check("t1_period",    32'(bus.period),    32'd26);
        check("t1_high_time", 32'(bus.high_time), 32'd13);

        // 2: period 32 and then 28, both outside tolerance
        pulses(16, 16, 4);
        check_status("t2a");
        pulse(14, 14);
        check_status("t2b");
        check("t2_err_pulses", 32'(err_seen), 32'(exp_errs_total));

        // 3: relock, then 25 and 27 stay inside tolerance
        pulses(13, 13, 5);
        check_status("t3a");
        pulses(13, 12, 2);
        pulses(14, 13, 2);
        pulse(13, 13);
        check_status("t3b");
        check("t3_period",    32'(bus.period),    32'd27);
        check("t3_high_time", 32'(bus.high_time), 32'd14);

        // 4: dead clock after lock, recovery, then clr
        idle(224);
        check("t4_timeout_early", 32'(bus.timeout), 32'd0);
        idle(10);
        model_restart();
        check("t4_timeout", 32'(bus.timeout), 32'd1);
        check_status("t4a");
        pulses(13, 13, 6);
        check_status("t4b");
        check("t4_timeout_sticky", 32'(bus.timeout), 32'd1);
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        model_restart();
        exp_err = 0;
        idle(2);
        check("t4_clr_timeout", 32'(bus.timeout), 32'd0);
        check_status("t4c");

        // 5: asynchronous reset in the middle of a high phase
        pulses(13, 13, 5);
        check_status("t5a");
        if (armed) model_meas(prev_hi + prev_lo, prev_hi);
        bus.sig_in = 1'b1;
        idle(6);
        rst = 1'b0;
        #1;
        check("t5_period",     32'(bus.period),     32'd0);
        check("t5_high_time",  32'(bus.high_time),  32'd0);
        check("t5_meas_valid", 32'(bus.meas_valid), 32'd0);
        check("t5_locked",     32'(bus.locked),     32'd0);
        check("t5_err_pulse",  32'(bus.err_pulse),  32'd0);
        check("t5_err_count",  32'(bus.err_count),  32'd0);
        check("t5_timeout",    32'(bus.timeout),    32'd0);
        model_restart();
        exp_err = 0;
        bus.sig_in = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(3);
        pulses(13, 13, 3);
        check("t5_meas_count", 32'(meas_seen), 32'(meas_pushed));
        check_status("t5b");

        // 6: saturate the mismatch counter, then clr
        pulses(16, 16, 301);
        check_status("t6a");
        check("t6_err_sat", 32'(bus.err_count), 32'd255);
        bus.clr = 1'b1;
        idle(1);
        bus.clr = 1'b0;
        model_restart();
        exp_err = 0;
        idle(2);
        check("t6_clr_err_count", 32'(bus.err_count), 32'd0);
        pulse(16, 16);
        pulse(13, 13);
        idle(5);
        check_status("t6b");

        // Final bookkeeping
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_meas_count",  32'(meas_seen),    32'(meas_pushed));
        check("end_err_pulses",  32'(err_seen),     32'(exp_errs_total));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
